// File: rtl/cache_assoc.sv
// Set-associative, write-through, no-write-allocate cache with burst line refill
// over a handshaked system bus and tree pseudo-LRU replacement.
module cache_assoc #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 4,
  parameter int OFF_W   = 2,
  parameter int WAYS    = 2,
  parameter int TAG_W   = ADDR_W - INDEX_W - OFF_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PStrobe,
  input  logic [ADDR_W-1:0] PAddress,
  input  logic              PRW,
  input  logic [2:0]        FUNC3,
  input  logic [31:0]       PWData,
  input  logic              CacheInv,
  output logic [31:0]       PRData,
  output logic              PReady,
  output logic              PErr,
  output logic              SysStrobe,
  output logic              SysRW,
  output logic [ADDR_W-1:0] SysAddress,
  output logic [31:0]       SysWData,
  output logic [3:0]        SysWStrb,
  input  logic [31:0]       SysRData,
  input  logic              SysReady
);
  localparam int SETS       = 1 << INDEX_W;
  localparam int LINE_WORDS = 1 << OFF_W;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W     = (WAYS > 1) ? WAYS - 1 : 1;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, DONE} state_t;

  state_t state;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS*LINE_WORDS];

  logic [ADDR_W-1:0] req_addr;
  logic              req_rd;
  logic [2:0]        req_f3;
  logic [31:0]       req_wdata;
  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  count_q;
  logic [OFF_W-1:0]  count_nxt;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [OFF_W-1:0]   req_off;
  logic [1:0]         req_byte;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign req_index = req_addr[2+OFF_W +: INDEX_W];
  assign req_off   = req_addr[2 +: OFF_W];
  assign req_byte  = req_addr[1:0];
  assign count_nxt = count_q + 1'b1;

  // Tree PLRU: bit 0 picks the half holding the victim, bits 1/2 pick within a pair.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
    logic [2:0] b;
    logic [1:0] v;
    b = 3'(bits);
    v = 2'b00;
    if (WAYS == 2) v = {1'b0, b[0]};
    else if (WAYS == 4) v = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    return WAY_W'(v);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
    logic [2:0] b;
    logic [1:0] w;
    b = 3'(bits);
    w = 2'(way);
    if (WAYS == 2) begin
      b[0] = ~w[0];
    end else if (WAYS == 4) begin
      b[0] = ~w[1];
      if (w[1]) b[2] = ~w[0];
      else b[1] = ~w[0];
    end
    return PLRU_W'(b);
  endfunction

  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] bsel);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{bsel, 3'b000} +: 8];
    h = bsel[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              inv_found;
  logic              req_err;
  logic [31:0]       st_data;
  logic [3:0]        st_strb;
  logic [31:0]       hit_word;
  logic [31:0]       merged;
  logic              rd_hit;
  logic              wr_hit;
  logic              refill_beat;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_index][w] && tag_q[w][req_index] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // An empty way is always preferred over evicting live data.
  always_comb begin
    victim    = plru_victim(plru_q[req_index]);
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[req_index][w]) begin
        victim    = WAY_W'(w);
        inv_found = 1'b1;
      end
    end
  end

  always_comb begin
    case (req_f3)
      3'b000:  req_err = 1'b0;
      3'b001:  req_err = req_byte[0];
      3'b010:  req_err = (req_byte != 2'b00);
      3'b100:  req_err = !req_rd;
      3'b101:  req_err = !req_rd || req_byte[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    st_data = req_wdata;
    st_strb = 4'b1111;
    case (req_f3[1:0])
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_strb = 4'b0001 << req_byte;
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_strb = req_byte[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign hit_word = data_q[hit_way][{req_index, req_off}];

  always_comb begin
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = st_strb[i] ? st_data[8*i +: 8] : hit_word[8*i +: 8];
  end

  assign rd_hit      = (state == LOOKUP) && !req_err && req_rd && hit;
  assign wr_hit      = (state == LOOKUP) && !req_err && !req_rd && hit;
  assign refill_beat = (state == REFILL) && SysStrobe && SysReady;

  assign PReady = ((state == LOOKUP) && (req_err || rd_hit)) || (state == DONE);
  assign PErr   = (state == LOOKUP) && req_err;
  assign PRData = rd_hit ? load_format(hit_word, req_f3, req_byte) : 32'h0;

  // Tag and data arrays need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (refill_beat) data_q[victim_q][{req_index, count_q}] <= SysRData;
    if (refill_beat && count_q == LAST_WORD) tag_q[victim_q][req_index] <= req_tag;
    if (wr_hit) data_q[hit_way][{req_index, req_off}] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_rd     <= 1'b0;
      req_f3     <= 3'b000;
      req_wdata  <= 32'h0;
      victim_q   <= '0;
      count_q    <= '0;
      SysStrobe  <= 1'b0;
      SysRW      <= 1'b0;
      SysAddress <= '0;
      SysWData   <= 32'h0;
      SysWStrb   <= 4'b0000;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (PStrobe) begin
            req_addr  <= PAddress;
            req_rd    <= PRW;
            req_f3    <= FUNC3;
            req_wdata <= PWData;
            state     <= LOOKUP;
          end else if (CacheInv) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end
        end
        LOOKUP: begin
          if (req_err) begin
            state <= IDLE;
          end else if (req_rd) begin
            if (hit) begin
              plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
              state             <= IDLE;
            end else begin
              victim_q   <= victim;
              count_q    <= '0;
              SysStrobe  <= 1'b1;
              SysRW      <= 1'b0;
              SysAddress <= {req_tag, req_index, {OFF_W{1'b0}}, 2'b00};
              state      <= REFILL;
            end
          end else begin
            if (hit) plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way);
            SysStrobe  <= 1'b1;
            SysRW      <= 1'b1;
            SysAddress <= {req_addr[ADDR_W-1:2], 2'b00};
            SysWData   <= st_data;
            SysWStrb   <= st_strb;
            state      <= WRITE;
          end
        end
        REFILL: begin
          if (refill_beat) begin
            if (count_q == '0) valid_q[req_index][victim_q] <= 1'b0;
            if (count_q == LAST_WORD) begin
              valid_q[req_index][victim_q] <= 1'b1;
              SysStrobe <= 1'b0;
              state     <= LOOKUP;
            end else begin
              count_q    <= count_nxt;
              SysAddress <= {req_tag, req_index, count_nxt, 2'b00};
            end
          end
        end
        WRITE: begin
          if (SysReady) begin
            SysStrobe <= 1'b0;
            SysRW     <= 1'b0;
            SysWStrb  <= 4'b0000;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Directed testbench for cache_assoc with a word-addressed memory model
// whose unwritten words read back as their own byte address.
module tb_cache_assoc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PStrobe = 1'b0;
  logic [15:0] PAddress = '0;
  logic        PRW = 1'b0;
  logic [2:0]  FUNC3 = 3'b000;
  logic [31:0] PWData = '0;
  logic        CacheInv = 1'b0;
  logic [31:0] PRData;
  logic        PReady, PErr, SysStrobe, SysRW, SysReady;
  logic [15:0] SysAddress;
  logic [31:0] SysWData, SysRData;
  logic [3:0]  SysWStrb;
  logic        sys_ready_en = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [16384];
  bit          mem_ready = 1'b0;
  logic [15:0] beat_log [$];

  int          lat, strobe_cyc, beat_base, beats;
  logic [31:0] rdata, s_wdata;
  logic        err;
  logic [15:0] s_addr;
  logic [3:0]  s_strb;

  cache_assoc dut (
    .clk(clk), .rst(rst), .PStrobe(PStrobe), .PAddress(PAddress), .PRW(PRW),
    .FUNC3(FUNC3), .PWData(PWData), .CacheInv(CacheInv), .PRData(PRData),
    .PReady(PReady), .PErr(PErr), .SysStrobe(SysStrobe), .SysRW(SysRW),
    .SysAddress(SysAddress), .SysWData(SysWData), .SysWStrb(SysWStrb),
    .SysRData(SysRData), .SysReady(SysReady)
  );

  always #5 clk = ~clk;

  assign SysReady = sys_ready_en;
  assign SysRData = mem[SysAddress[15:2]];

  // Memory model: applies write beats byte by byte and logs every read beat address.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'(i * 4);
      mem_ready = 1'b1;
    end else if (SysStrobe && SysReady) begin
      if (SysRW) begin
        for (int b = 0; b < 4; b++)
          if (SysWStrb[b]) mem[SysAddress[15:2]][8*b +: 8] = SysWData[8*b +: 8];
      end else begin
        beat_log.push_back(SysAddress);
      end
    end
  end

  task automatic do_access(input logic [15:0] addr, input logic rd, input logic [2:0] f3,
                           input logic [31:0] wd, input logic inv);
    @(posedge clk); #1;
    beat_base = beat_log.size();
    PStrobe = 1'b1; PAddress = addr; PRW = rd; FUNC3 = f3; PWData = wd; CacheInv = inv;
    @(posedge clk); #1;
    PStrobe = 1'b0; CacheInv = 1'b0;
    lat = -1; strobe_cyc = -1; rdata = '0; err = 1'b0; s_addr = '0; s_wdata = '0; s_strb = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (SysStrobe && strobe_cyc < 0) begin
        strobe_cyc = c; s_addr = SysAddress; s_wdata = SysWData; s_strb = SysWStrb;
      end
      if (PReady) begin
        lat = c; rdata = PRData; err = PErr;
        break;
      end
      @(posedge clk); #1;
    end
    beats = beat_log.size() - beat_base;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({PReady, PErr, SysStrobe, SysRW, SysWStrb} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00000000", {PReady, PErr, SysStrobe, SysRW, SysWStrb});
    end
    tests_run++;
    if ({PRData, SysAddress, SysWData} !== 80'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got %h/%h/%h, expected zeros", PRData, SysAddress, SysWData);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    do_access(16'h0124, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 6 || rdata !== 32'h00000124 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cold_read: got lat %0d data %h err %b, expected 6 00000124 0", lat, rdata, err);
    end
    tests_run++;
    if (beats !== 4) begin
      tests_failed++;
      $display("[TB] FAIL cold_beats: got %0d, expected 4", beats);
    end
    for (int i = 0; i < 4; i++) begin
      logic [15:0] got;
      got = (beats > i) ? beat_log[beat_base + i] : 16'hFFFF;
      tests_run++;
      if (got !== 16'h0120 + 16'(4 * i)) begin
        tests_failed++;
        $display("[TB] FAIL cold_beat_addr%0d: got %h, expected %h", i, got, 16'h0120 + 16'(4 * i));
      end
    end
    do_access(16'h0124, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || rdata !== 32'h00000124 || strobe_cyc !== -1) begin
      tests_failed++;
      $display("[TB] FAIL repeat_hit: got lat %0d data %h strobe %0d, expected 1 00000124 -1", lat, rdata, strobe_cyc);
    end
  endtask

  task automatic test_byte_store();
    do_access(16'h0131, 1'b0, 3'b000, 32'h000000A5, 1'b0);
    tests_run++;
    if (s_strb !== 4'b0010 || s_wdata !== 32'hA5A5A5A5 || s_addr !== 16'h0130) begin
      tests_failed++;
      $display("[TB] FAIL sb_bus: got strb %b data %h addr %h, expected 0010 a5a5a5a5 0130", s_strb, s_wdata, s_addr);
    end
    tests_run++;
    if (strobe_cyc !== 2 || lat !== 3 || err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sb_timing: got strobe %0d ready %0d err %b, expected 2 3 0", strobe_cyc, lat, err);
    end
    do_access(16'h0131, 1'b1, 3'b000, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 6 || rdata !== 32'hFFFFFFA5) begin
      tests_failed++;
      $display("[TB] FAIL lb_refill: got lat %0d data %h, expected 6 ffffffa5", lat, rdata);
    end
    do_access(16'h0131, 1'b1, 3'b100, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || rdata !== 32'h000000A5) begin
      tests_failed++;
      $display("[TB] FAIL lbu_hit: got lat %0d data %h, expected 1 000000a5", lat, rdata);
    end
    do_access(16'h0130, 1'b1, 3'b001, 32'h0, 1'b0);
    tests_run++;
    if (rdata !== 32'hFFFFA530) begin
      tests_failed++;
      $display("[TB] FAIL lh_sign: got %h, expected ffffa530", rdata);
    end
    do_access(16'h0130, 1'b1, 3'b101, 32'h0, 1'b0);
    tests_run++;
    if (rdata !== 32'h0000A530) begin
      tests_failed++;
      $display("[TB] FAIL lhu_zero: got %h, expected 0000a530", rdata);
    end
  endtask

  task automatic test_conflict();
    logic [15:0] seq_addr [7] = '{16'h0000, 16'h0400, 16'h0000, 16'h0800, 16'h0000, 16'h0800, 16'h0400};
    int          seq_lat  [7] = '{6, 6, 1, 6, 1, 1, 6};
    for (int i = 0; i < 7; i++) begin
      do_access(seq_addr[i], 1'b1, 3'b010, 32'h0, 1'b0);
      tests_run++;
      if (lat !== seq_lat[i] || rdata !== {16'h0, seq_addr[i]}) begin
        tests_failed++;
        $display("[TB] FAIL conflict_step%0d: got lat %0d data %h, expected %0d %h", i, lat, rdata, seq_lat[i], {16'h0, seq_addr[i]});
      end
    end
  endtask

  task automatic test_errors_and_write_miss();
    do_access(16'h0003, 1'b1, 3'b001, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || err !== 1'b1 || strobe_cyc !== -1 || beats !== 0) begin
      tests_failed++;
      $display("[TB] FAIL lh_misaligned: got lat %0d err %b strobe %0d beats %0d, expected 1 1 -1 0", lat, err, strobe_cyc, beats);
    end
    do_access(16'h0122, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL lw_misaligned: got lat %0d err %b, expected 1 1", lat, err);
    end
    do_access(16'h0120, 1'b1, 3'b011, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_func3: got lat %0d err %b, expected 1 1", lat, err);
    end
    do_access(16'h2000, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0);
    tests_run++;
    if (lat !== 3 || s_strb !== 4'b1111 || s_wdata !== 32'hDEADBEEF || beats !== 0) begin
      tests_failed++;
      $display("[TB] FAIL sw_miss: got lat %0d strb %b data %h beats %0d, expected 3 1111 deadbeef 0", lat, s_strb, s_wdata, beats);
    end
    do_access(16'h0400, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL sw_miss_keeps_b: got lat %0d, expected 1", lat);
    end
    do_access(16'h0800, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL sw_miss_keeps_c: got lat %0d, expected 1", lat);
    end
    do_access(16'h2000, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 6 || rdata !== 32'hDEADBEEF || beats !== 4) begin
      tests_failed++;
      $display("[TB] FAIL lw_after_sw: got lat %0d data %h beats %0d, expected 6 deadbeef 4", lat, rdata, beats);
    end
  endtask

  task automatic test_write_hit();
    do_access(16'h0128, 1'b0, 3'b010, 32'h12345678, 1'b0);
    tests_run++;
    if (strobe_cyc !== 2 || lat !== 3 || s_addr !== 16'h0128) begin
      tests_failed++;
      $display("[TB] FAIL sw_hit_timing: got strobe %0d ready %0d addr %h, expected 2 3 0128", strobe_cyc, lat, s_addr);
    end
    do_access(16'h0128, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || rdata !== 32'h12345678) begin
      tests_failed++;
      $display("[TB] FAIL sw_hit_merge: got lat %0d data %h, expected 1 12345678", lat, rdata);
    end
    do_access(16'h012E, 1'b0, 3'b001, 32'h0000BEEF, 1'b0);
    tests_run++;
    if (s_strb !== 4'b1100 || s_wdata !== 32'hBEEFBEEF || s_addr !== 16'h012C) begin
      tests_failed++;
      $display("[TB] FAIL sh_bus: got strb %b data %h addr %h, expected 1100 beefbeef 012c", s_strb, s_wdata, s_addr);
    end
    do_access(16'h012E, 1'b1, 3'b001, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || rdata !== 32'hFFFFBEEF) begin
      tests_failed++;
      $display("[TB] FAIL lh_after_sh: got lat %0d data %h, expected 1 ffffbeef", lat, rdata);
    end
    do_access(16'h012C, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1 || rdata !== 32'hBEEF012C) begin
      tests_failed++;
      $display("[TB] FAIL lw_after_sh: got lat %0d data %h, expected 1 beef012c", lat, rdata);
    end
  endtask

  task automatic test_invalidate();
    @(posedge clk); #1;
    CacheInv = 1'b1;
    @(posedge clk); #1;
    CacheInv = 1'b0;
    do_access(16'h0124, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 6 || rdata !== 32'h00000124) begin
      tests_failed++;
      $display("[TB] FAIL inv_refill: got lat %0d data %h, expected 6 00000124", lat, rdata);
    end
    do_access(16'h0124, 1'b1, 3'b010, 32'h0, 1'b1);
    do_access(16'h0124, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("[TB] FAIL inv_dropped: got lat %0d, expected 1", lat);
    end
  endtask

  task automatic test_stall();
    int stable_bad = 0;
    @(posedge clk); #1;
    beat_base = beat_log.size();
    sys_ready_en = 1'b0;
    PStrobe = 1'b1; PAddress = 16'h0250; PRW = 1'b1; FUNC3 = 3'b010;
    @(posedge clk); #1;
    PStrobe = 1'b0;
    lat = -1; rdata = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 7) sys_ready_en = 1'b1;
      @(negedge clk);
      if (c >= 2 && c <= 6 && (SysStrobe !== 1'b1 || SysAddress !== 16'h0250)) stable_bad++;
      if (PReady) begin
        lat = c; rdata = PRData;
        break;
      end
      @(posedge clk); #1;
    end
    sys_ready_en = 1'b1;
    tests_run++;
    if (stable_bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: got %0d unstable cycles, expected 0", stable_bad);
    end
    tests_run++;
    if (lat !== 11 || rdata !== 32'h00000250 || beat_log.size() - beat_base !== 4) begin
      tests_failed++;
      $display("[TB] FAIL stall_latency: got lat %0d data %h, expected 11 00000250", lat, rdata);
    end
  endtask

  task automatic test_reset_mid();
    int ready_seen = 0;
    @(posedge clk); #1;
    beat_base = beat_log.size();
    PStrobe = 1'b1; PAddress = 16'h0360; PRW = 1'b1; FUNC3 = 3'b010;
    @(posedge clk); #1;
    PStrobe = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({PReady, PErr, SysStrobe, SysRW, SysWStrb, PRData, SysAddress, SysWData} !== 88'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: got strobe %b addr %h ready %b, expected all zero", SysStrobe, SysAddress, PReady);
    end
    tests_run++;
    if (beat_log.size() - beat_base !== 2) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_beats: got %0d, expected 2", beat_log.size() - beat_base);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (PReady) ready_seen++;
    end
    tests_run++;
    if (ready_seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_no_ready: got %0d pulses, expected 0", ready_seen);
    end
    do_access(16'h0360, 1'b1, 3'b010, 32'h0, 1'b0);
    tests_run++;
    if (lat !== 6 || beats !== 4 || rdata !== 32'h00000360) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_refetch: got lat %0d beats %0d data %h, expected 6 4 00000360", lat, beats, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_byte_store();
    test_conflict();
    test_errors_and_write_miss();
    test_write_hit();
    test_invalidate();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
